// File: rtl/timer_pkg.sv
// Shared constants for the interval timer: controller state encoding,
// interval counter width and the 10 s counter length in 1 s ticks.
package timer_pkg;

   localparam int IVAL_W         = 8;
   localparam int CNT_10S_CYCLES = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_GAP    = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

endpackage

// File: rtl/cnt_10s.sv
// Counts enabled 1 s ticks and raises a sticky flag after ten of them;
// dropping the enable clears both the count and the flag.
module cnt_10s
   import timer_pkg::*;
(
   input  logic clk_out,
   input  logic rst_n,
   input  logic en_cnt_10s,
   output logic cnt_out_10s
);

   localparam int CW = $clog2(CNT_10S_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_10S_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          flag_q, flag_d;

   always_comb begin
      cnt_d  = cnt_q;
      flag_d = flag_q;
      if (!en_cnt_10s) begin
         cnt_d  = '0;
         flag_d = 1'b0;
      end else if (!flag_q) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            flag_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign cnt_out_10s = flag_q;

endmodule

// File: rtl/interval_timer_top.sv
// Test wrapper pairing the run controller with its 10 s counter.
module interval_timer_top
   import timer_pkg::*;
#(
   parameter int N_INTERVALS = 6
) (
   input  logic              clk_out,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              en_cnt_10s,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [IVAL_W-1:0] ival_cnt
);

   logic cnt_out_10s;

   interval_ctrl #(.N_INTERVALS(N_INTERVALS)) u_ctrl (
      .clk_out     (clk_out),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .cnt_out_10s (cnt_out_10s),
      .en_cnt_10s  (en_cnt_10s),
      .busy        (busy),
      .done        (done),
      .aborted     (aborted),
      .ival_cnt    (ival_cnt)
   );

   cnt_10s u_cnt (
      .clk_out     (clk_out),
      .rst_n       (rst_n),
      .en_cnt_10s  (en_cnt_10s),
      .cnt_out_10s (cnt_out_10s)
   );

endmodule

// File: rtl/interval_ctrl.sv
// Run controller: sequences N_INTERVALS ten-second intervals through an
// external cnt_10s, with abort, a one-cycle gap between intervals and done.
module interval_ctrl
   import timer_pkg::*;
#(
   parameter int N_INTERVALS = 6
) (
   input  logic              clk_out,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              cnt_out_10s,
   output logic              en_cnt_10s,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [IVAL_W-1:0] ival_cnt
);

   localparam logic [IVAL_W-1:0] N_LAST = IVAL_W'(N_INTERVALS);

   state_e            state_q, state_d;
   logic [IVAL_W-1:0] ival_q, ival_d, ival_inc;
   logic              en_q, en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;

   // Outputs are computed for the state being entered, then registered.
   always_comb begin
      state_d   = state_q;
      ival_d    = ival_q;
      ival_inc  = ival_q + 8'd1;
      en_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_RUN;
               ival_d  = '0;
               en_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
            end else if (cnt_out_10s) begin
               ival_d = ival_inc;
               busy_d = 1'b1;
               if (ival_inc == N_LAST) begin
                  state_d = ST_FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_GAP;
               end
            end else begin
               en_d   = 1'b1;
               busy_d = 1'b1;
            end
         end
         // Enable held low for this one cycle so cnt_10s drops its flag.
         ST_GAP: begin
            if (abort) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
            end else begin
               state_d = ST_RUN;
               en_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ival_q    <= '0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ival_q    <= ival_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign en_cnt_10s = en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign ival_cnt   = ival_q;

endmodule

// File: tb/tb_interval_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed expectations per cycle,
// a monitor pops and compares them just after each rising clock edge.
module tb_interval_ctrl;

   localparam logic [3:0] E_IDLE = 4'b0000;  // {en, busy, done, aborted}
   localparam logic [3:0] E_RUN  = 4'b1100;
   localparam logic [3:0] E_GAP  = 4'b0100;
   localparam logic [3:0] E_FIN  = 4'b0110;
   localparam logic [3:0] E_ABT  = 4'b0001;

   typedef struct {
      int         sel;
      logic [3:0] e;
      logic [7:0] iv;
      string      nm;
   } exp_t;

   logic clk_out = 1'b0;
   logic rst_n   = 1'b0;

   logic       start_a = 0, abort_a = 0, cnt_a = 0;
   logic       en_a, busy_a, done_a, ab_a;
   logic [7:0] ival_a;
   logic       start_b = 0, abort_b = 0, cnt_b = 0;
   logic       en_b, busy_b, done_b, ab_b;
   logic [7:0] ival_b;
   logic       start_w = 0, abort_w = 0;
   logic       en_w, busy_w, done_w, ab_w;
   logic [7:0] ival_w;

   exp_t exp_q[$];
   exp_t item;
   int   cur_sel = 0;
   int   checks  = 0;
   int   errors  = 0;

   always #5 clk_out = ~clk_out;

   interval_ctrl #(.N_INTERVALS(6)) u_dut_a (
      .clk_out(clk_out), .rst_n(rst_n), .start(start_a), .abort(abort_a),
      .cnt_out_10s(cnt_a), .en_cnt_10s(en_a), .busy(busy_a), .done(done_a),
      .aborted(ab_a), .ival_cnt(ival_a)
   );

   interval_ctrl #(.N_INTERVALS(1)) u_dut_b (
      .clk_out(clk_out), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .cnt_out_10s(cnt_b), .en_cnt_10s(en_b), .busy(busy_b), .done(done_b),
      .aborted(ab_b), .ival_cnt(ival_b)
   );

   interval_timer_top #(.N_INTERVALS(3)) u_dut_w (
      .clk_out(clk_out), .rst_n(rst_n), .start(start_w), .abort(abort_w),
      .en_cnt_10s(en_w), .busy(busy_w), .done(done_w), .aborted(ab_w),
      .ival_cnt(ival_w)
   );

   function automatic logic [11:0] actual(input int sel);
      case (sel)
         0:       return {en_a, busy_a, done_a, ab_a, ival_a};
         1:       return {en_b, busy_b, done_b, ab_b, ival_b};
         default: return {en_w, busy_w, done_w, ab_w, ival_w};
      endcase
   endfunction

   task automatic compare(input int sel, input logic [3:0] e, input logic [7:0] iv,
                          input string nm);
      logic [11:0] act;
      act = actual(sel);
      checks++;
      if (act !== {e, iv}) begin
         errors++;
         $display("FAIL %s (dut %0d): got en/busy/done/aborted=%b ival=%0d, expected %b ival=%0d",
                  nm, sel, act[11:8], act[7:0], e, iv);
      end
   endtask

   // Drive one cycle of inputs on the falling edge and queue the outputs
   // expected after the following rising edge.
   task automatic step(input logic st, input logic ab, input logic cn,
                       input logic [3:0] e, input logic [7:0] iv, input string nm);
      exp_t x;
      @(negedge clk_out);
      start_a = 0; abort_a = 0; cnt_a = 0;
      start_b = 0; abort_b = 0; cnt_b = 0;
      start_w = 0; abort_w = 0;
      case (cur_sel)
         0: begin start_a = st; abort_a = ab; cnt_a = cn; end
         1: begin start_b = st; abort_b = ab; cnt_b = cn; end
         default: begin start_w = st; abort_w = ab; end
      endcase
      x.sel = cur_sel; x.e = e; x.iv = iv; x.nm = nm;
      exp_q.push_back(x);
   endtask

   task automatic run(input int k, input logic [7:0] iv, input logic st);
      repeat (k) step(st, 1'b0, 1'b0, E_RUN, iv, "run");
   endtask

   initial begin
      forever begin
         @(posedge clk_out);
         #1;
         if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            compare(item.sel, item.e, item.iv, item.nm);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      #2;
      compare(0, E_IDLE, 8'd0, "reset_a");
      compare(1, E_IDLE, 8'd0, "reset_b");
      compare(2, E_IDLE, 8'd0, "reset_w");
      @(negedge clk_out);
      rst_n = 1'b1;

      // Wrapper with real cnt_10s, three intervals of 12 cycles each.
      cur_sel = 2;
      step(1, 0, 0, E_RUN, 8'd0, "w_start");
      for (int k = 1; k <= 2; k++) begin
         run(10, 8'(k - 1), 1'b0);
         step(0, 0, 0, E_GAP, 8'(k), "w_gap");
         step(0, 0, 0, E_RUN, 8'(k), "w_gap_exit");
      end
      run(10, 8'd2, 1'b0);
      step(0, 0, 0, E_FIN, 8'd3, "w_done");
      step(0, 0, 0, E_IDLE, 8'd3, "w_busy_fall");

      // Six intervals with starts in RUN/GAP and a stale flag in GAP.
      cur_sel = 0;
      step(1, 0, 0, E_RUN, 8'd0, "a_start");
      run(1, 8'd0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         step(0, 0, 1, E_GAP, 8'(k), "a_gap");
         step((k == 2), 0, 1, E_RUN, 8'(k), "a_gap_exit");
         run(1, 8'(k), 1'b0);
      end
      step(0, 0, 1, E_FIN, 8'd6, "a_done");
      step(1, 1, 1, E_IDLE, 8'd6, "a_finish_ignores");
      step(0, 0, 1, E_IDLE, 8'd6, "a_idle_cnt_ignored");
      step(1, 1, 0, E_IDLE, 8'd6, "a_start_abort_idle");

      // Abort mid-RUN after two intervals.
      step(1, 0, 0, E_RUN, 8'd0, "a2_start");
      run(2, 8'd0, 1'b0);
      step(0, 0, 1, E_GAP, 8'd1, "a2_gap1");
      step(0, 0, 0, E_RUN, 8'd1, "a2_run1");
      step(0, 0, 1, E_GAP, 8'd2, "a2_gap2");
      step(0, 0, 0, E_RUN, 8'd2, "a2_run2");
      run(2, 8'd2, 1'b0);
      step(0, 1, 0, E_ABT, 8'd2, "abort_run");
      step(0, 0, 0, E_IDLE, 8'd2, "after_abort");

      // Abort while in GAP.
      step(1, 0, 0, E_RUN, 8'd0, "a3_start");
      step(0, 0, 1, E_GAP, 8'd1, "a3_gap");
      step(0, 1, 0, E_ABT, 8'd1, "abort_gap");
      step(0, 0, 0, E_IDLE, 8'd1, "after_abort_gap");

      // Abort and flag on the same edge: abort wins, no increment.
      step(1, 0, 0, E_RUN, 8'd0, "a4_start");
      step(0, 1, 1, E_ABT, 8'd0, "collision");
      step(0, 0, 0, E_IDLE, 8'd0, "after_collision");

      // Single interval with start held: back-to-back runs.
      cur_sel = 1;
      step(1, 0, 0, E_RUN, 8'd0, "b_start");
      step(1, 0, 1, E_FIN, 8'd1, "b_done");
      step(1, 0, 0, E_IDLE, 8'd1, "b_idle");
      step(1, 0, 0, E_RUN, 8'd0, "b_restart");
      step(0, 0, 1, E_FIN, 8'd1, "b_done2");
      step(0, 0, 0, E_IDLE, 8'd1, "b_idle2");

      // Asynchronous reset between edges with four intervals done.
      cur_sel = 0;
      step(1, 0, 0, E_RUN, 8'd0, "a5_start");
      for (int k = 1; k <= 4; k++) begin
         step(0, 0, 1, E_GAP, 8'(k), "a5_gap");
         step(0, 0, 0, E_RUN, 8'(k), "a5_run");
      end
      step(0, 0, 0, E_RUN, 8'd4, "a5_run4");
      @(posedge clk_out);
      #3;
      rst_n = 1'b0;
      #1;
      compare(0, E_IDLE, 8'd0, "async_rst_a");
      compare(1, E_IDLE, 8'd0, "async_rst_b");
      step(0, 0, 0, E_IDLE, 8'd0, "rst_hold");
      step(1, 0, 0, E_RUN, 8'd0, "first_edge_after_rst");
      rst_n = 1'b1;
      run(1, 8'd0, 1'b0);
      step(0, 1, 0, E_ABT, 8'd0, "a6_abort");
      step(0, 0, 0, E_IDLE, 8'd0, "a6_idle");

      repeat (2) @(posedge clk_out);
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
